// File: rtl/iq_pull_packer_if.sv
// Stream bundle around the I/Q packer: NUM_SRC multi-lane I/Q sources in, one packed word stream out.
// The slave modport is the packer's view; master is the surrounding environment.
interface iq_pull_packer_if #(
  parameter int NUM_SRC   = 3,
  parameter int NUM_LANES = 8,
  parameter int SAMPLE_W  = 16,
  parameter int OUT_W     = 64
);
  logic [NUM_SRC-1:0]                    s_axis_tvalid;
  logic [NUM_SRC-1:0]                    s_axis_tready;
  logic [NUM_SRC-1:0]                    s_axis_tlast;
  logic [NUM_SRC*NUM_LANES*SAMPLE_W-1:0] s_axis_i_tdata;
  logic [NUM_SRC*NUM_LANES*SAMPLE_W-1:0] s_axis_q_tdata;

  logic                                  m_axis_tvalid;
  logic                                  m_axis_tready;
  logic [OUT_W-1:0]                      m_axis_tdata;
  logic                                  m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_i_tdata, s_axis_q_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_i_tdata, s_axis_q_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/iq_pull_packer.sv
// Selects one multi-lane I/Q source per capture session, buffers its beats and serialises
// each beat into OUT_W-bit words of {Q,I} pairs with framed tlast.
module iq_pull_packer #(
  parameter int NUM_SRC     = 3,
  parameter int NUM_LANES   = 8,
  parameter int SAMPLE_W    = 16,
  parameter int OUT_W       = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 256,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      src_sel,
  iq_pull_packer_if.slave       axis,
  output logic                  busy,
  output logic [31:0]           frame_cnt
);

  localparam int PAIR_W = 2 * SAMPLE_W;
  localparam int P      = OUT_W / PAIR_W;
  localparam int WPB    = NUM_LANES / P;
  localparam int BEAT_W = NUM_LANES * SAMPLE_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int KW     = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int FW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] q;
    logic [BEAT_W-1:0] i;
  } beat_t;

  state_t              state;
  logic [SEL_W-1:0]    sel;

  beat_t               mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, count, count_next;
  beat_t               in_beat, head;

  logic                push, pop, load, last_word, fifo_empty;
  logic                tlast_next, drain_done, sel_ready_next, sel_ok;
  logic [KW-1:0]       k;
  logic [FW-1:0]       word_cnt;
  logic [2*BEAT_W-1:0] pairs;
  logic [OUT_W-1:0]    word;

  // Ready pattern: every non-selected source is held ready so its beats are discarded.
  function automatic logic [NUM_SRC-1:0] ready_mask(input logic [SEL_W-1:0] s, input logic open);
    logic [NUM_SRC-1:0] one;
    one = NUM_SRC'(1) << s;
    return ~one | (open ? one : '0);
  endfunction

  assign busy       = (state != IDLE);
  assign sel_ok     = (int'(src_sel) < NUM_SRC);
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign push       = (state == STREAM) && axis.s_axis_tvalid[sel] && axis.s_axis_tready[sel];
  assign head       = mem[rd_ptr[AW-1:0]];
  assign load       = !fifo_empty && (!axis.m_axis_tvalid || axis.m_axis_tready);
  assign last_word  = (k == KW'(WPB - 1));
  assign pop        = load && last_word;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign sel_ready_next = (count_next != (AW+1)'(FIFO_DEPTH));
  assign drain_done = fifo_empty && (!axis.m_axis_tvalid || axis.m_axis_tready);

  // The DRAIN final word is the last word of the only beat left once capture has stopped.
  assign tlast_next = (last_word && head.last)
                   || (word_cnt == FW'(FRAME_WORDS - 1))
                   || ((state == DRAIN) && last_word && (count == (AW+1)'(1)));

  always_comb begin
    in_beat.i    = axis.s_axis_i_tdata[int'(sel)*BEAT_W +: BEAT_W];
    in_beat.q    = axis.s_axis_q_tdata[int'(sel)*BEAT_W +: BEAT_W];
    in_beat.last = axis.s_axis_tlast[sel];
  end

  always_comb begin
    // NOTE: a default before the loop keeps every bit assigned on every path, so no latch.
    pairs = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      pairs[l*PAIR_W +: PAIR_W] = {head.q[l*SAMPLE_W +: SAMPLE_W], head.i[l*SAMPLE_W +: SAMPLE_W]};
    end
  end

  assign word = pairs[int'(k)*OUT_W +: OUT_W];

  // NOTE: the beat storage has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_beat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Session control; source readies are registered from next-cycle FIFO occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      sel                <= '0;
      axis.s_axis_tready <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && sel_ok) begin
            state              <= STREAM;
            sel                <= src_sel;
            axis.s_axis_tready <= ready_mask(src_sel, sel_ready_next);
          end else begin
            axis.s_axis_tready <= '1;
          end
        end
        STREAM: begin
          if (!enable) begin
            state              <= DRAIN;
            axis.s_axis_tready <= ready_mask(sel, 1'b0);
          end else begin
            axis.s_axis_tready <= ready_mask(sel, sel_ready_next);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state              <= IDLE;
            axis.s_axis_tready <= '1;
          end else begin
            axis.s_axis_tready <= ready_mask(sel, 1'b0);
          end
        end
        default: begin
          state              <= IDLE;
          axis.s_axis_tready <= '1;
        end
      endcase
    end
  end

  // Output register: reloads whenever it is empty or being consumed, so no bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      axis.m_axis_tvalid <= 1'b0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tlast  <= 1'b0;
      k                  <= '0;
      word_cnt           <= '0;
      frame_cnt          <= '0;
    end else begin
      if (load) begin
        axis.m_axis_tvalid <= 1'b1;
        axis.m_axis_tdata  <= word;
        axis.m_axis_tlast  <= tlast_next;
        k                  <= last_word ? '0 : k + KW'(1);
        word_cnt           <= tlast_next ? '0 : word_cnt + FW'(1);
      end else if (axis.m_axis_tready) begin
        axis.m_axis_tvalid <= 1'b0;
      end
      if (axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_iq_pull_packer.sv
// Directed bench for iq_pull_packer: packing, framing, backpressure, drain, source select, reset.
module tb_iq_pull_packer;

  localparam int NUM_SRC     = 3;
  localparam int NUM_LANES   = 8;
  localparam int SAMPLE_W    = 16;
  localparam int OUT_W       = 64;
  localparam int FIFO_DEPTH  = 16;
  localparam int FRAME_WORDS = 256;
  localparam int BEAT_W      = NUM_LANES * SAMPLE_W;
  localparam int P           = OUT_W / (2 * SAMPLE_W);
  localparam int WPB         = NUM_LANES / P;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  src_sel;
  logic        busy;
  logic [31:0] frame_cnt;

  iq_pull_packer_if #(.NUM_SRC(NUM_SRC), .NUM_LANES(NUM_LANES), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W)) bus ();

  iq_pull_packer #(
    .NUM_SRC(NUM_SRC), .NUM_LANES(NUM_LANES), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .src_sel(src_sel),
    .axis(bus), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stab_err = 0;
  int beats_acc = 0;

  logic [63:0] got_w [$];
  logic        got_l [$];
  int          got_c [$];
  logic [63:0] exp_w [$];

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects handshaken words and flags any change while stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata !== prev_data || bus.m_axis_tlast !== prev_last))
        stab_err++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        got_w.push_back(bus.m_axis_tdata);
        got_l.push_back(bus.m_axis_tlast);
        got_c.push_back(cyc);
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      prev_last  = bus.m_axis_tlast;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] pack_word(input logic [BEAT_W-1:0] iv, input logic [BEAT_W-1:0] qv, input int k);
    logic [63:0] w;
    int lane;
    w = '0;
    for (int p = 0; p < P; p++) begin
      lane = k * P + p;
      w[p*32 +: 16]      = iv[lane*16 +: 16];
      w[p*32 + 16 +: 16] = qv[lane*16 +: 16];
    end
    return w;
  endfunction

  task automatic send_beat(input int s, input int ib, input int qb, input logic last);
    logic [BEAT_W-1:0] iv, qv;
    int guard;
    for (int l = 0; l < NUM_LANES; l++) begin
      iv[l*16 +: 16] = 16'(ib + l);
      qv[l*16 +: 16] = 16'(qb + l);
    end
    bus.s_axis_i_tdata[s*BEAT_W +: BEAT_W] = iv;
    bus.s_axis_q_tdata[s*BEAT_W +: BEAT_W] = qv;
    bus.s_axis_tlast[s]  = last;
    bus.s_axis_tvalid[s] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.s_axis_tready[s] && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid[s] = 1'b0;
    if (guard >= 3000) begin
      check("send_timeout", guard, 0);
    end else begin
      beats_acc++;
      for (int k = 0; k < WPB; k++) exp_w.push_back(pack_word(iv, qv, k));
    end
  endtask

  task automatic wait_words(input int n);
    int guard;
    guard = 0;
    while (got_w.size() < n && guard < 5000) begin
      tick(1);
      guard++;
    end
    if (guard >= 5000) check("wait_words_timeout", got_w.size(), n);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (guard >= 2000) check("wait_idle_timeout", busy, 0);
  endtask

  task automatic compare_stream(input string tag, input int n, input int tl_a, input int tl_b);
    int d_err;
    int l_err;
    logic exp_tl;
    d_err = 0;
    l_err = 0;
    check({tag, "_count"}, got_w.size(), n);
    for (int i = 0; i < got_w.size(); i++) begin
      if (i >= exp_w.size() || got_w[i] !== exp_w[i]) d_err++;
      exp_tl = (i == tl_a) || (i == tl_b);
      if (got_l[i] !== exp_tl) l_err++;
    end
    check({tag, "_data_errs"}, d_err, 0);
    check({tag, "_tlast_errs"}, l_err, 0);
    got_w.delete();
    got_l.delete();
    got_c.delete();
    exp_w.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    reset   = 1'b1;
    enable  = 1'b0;
    src_sel = 2'd0;
    bus.s_axis_tvalid  = '0;
    bus.s_axis_tlast   = '0;
    bus.s_axis_i_tdata = '0;
    bus.s_axis_q_tdata = '0;
    bus.m_axis_tready  = 1'b1;
    tick(2);

    // Reset state
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_tlast", bus.m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_s_tready", bus.s_axis_tready, 3'b000);
    reset = 1'b0;
    tick(1);
    check("idle_s_tready", bus.s_axis_tready, 3'b111);

    // 1: single beat with tlast, latency and first word
    src_sel = 2'd0;
    enable  = 1'b1;
    tick(2);
    check("t1_busy", busy, 1);
    send_beat(0, 'h0100, 'h0200, 1'b1);
    @(negedge clk);
    check("t1_lat_n1", bus.m_axis_tvalid, 0);
    @(negedge clk);
    check("t1_lat_n2", bus.m_axis_tvalid, 1);
    check("t1_word0", bus.m_axis_tdata, 64'h0201_0101_0200_0100);
    @(posedge clk);
    #1;
    wait_words(4);
    compare_stream("t1", 4, 3, -1);
    tick(2);
    check("t1_frame_cnt", frame_cnt, 1);
    enable = 1'b0;
    wait_idle();

    // 2: source 1, 128 back-to-back beats, frame-length tlast
    do_reset();
    src_sel = 2'd1;
    enable  = 1'b1;
    tick(2);
    for (int b = 0; b < 128; b++) send_beat(1, b * 256, 'h8000 + b * 256, 1'b0);
    wait_words(512);
    span = (got_c.size() > 0) ? got_c[got_c.size()-1] - got_c[0] : -1;
    check("t2_no_gaps_span", span, 511);
    compare_stream("t2", 512, 255, 511);
    tick(2);
    check("t2_frame_cnt", frame_cnt, 2);
    enable = 1'b0;
    wait_idle();

    // 3: output stalled for 100 cycles; src_sel change while streaming is ignored
    src_sel = 2'd1;
    enable  = 1'b1;
    tick(2);
    bus.m_axis_tready = 1'b0;
    src_sel   = 2'd0;
    beats_acc = 0;
    stab_err  = 0;
    fork
      begin
        for (int b = 0; b < 20; b++) send_beat(1, 'h1000 + b * 16, 'h2000 + b * 16, 1'b0);
      end
      begin
        tick(100);
        check("t3_beats_accepted", beats_acc, 16);
        check("t3_s_tready_full", bus.s_axis_tready, 3'b101);
        check("t3_hold_valid", bus.m_axis_tvalid, 1);
        check("t3_hold_data", bus.m_axis_tdata, exp_w[0]);
        bus.m_axis_tready = 1'b1;
      end
    join
    wait_words(80);
    check("t3_stable_errs", stab_err, 0);
    compare_stream("t3", 80, -1, -1);
    enable = 1'b0;
    wait_idle();

    // 4: drain with 5 beats queued
    src_sel = 2'd2;
    enable  = 1'b1;
    tick(2);
    bus.m_axis_tready = 1'b0;
    for (int b = 0; b < 5; b++) send_beat(2, 'h3000 + b * 16, 'h4000 + b * 16, 1'b0);
    enable = 1'b0;
    tick(3);
    check("t4_busy_drain", busy, 1);
    check("t4_s_tready_drain", bus.s_axis_tready, 3'b011);
    bus.m_axis_tready = 1'b1;
    wait_words(20);
    compare_stream("t4", 20, 19, -1);
    tick(3);
    check("t4_busy_fall", busy, 0);
    check("t4_frame_cnt", frame_cnt, 3);

    // 5: beat tlast coinciding with frame-length tlast; out-of-range source
    do_reset();
    src_sel = 2'd0;
    enable  = 1'b1;
    tick(2);
    for (int b = 0; b < 65; b++) send_beat(0, 'h5000 + b * 16, 'h6000 + b * 16, b == 63);
    wait_words(260);
    compare_stream("t5", 260, 255, -1);
    tick(2);
    check("t5_frame_cnt", frame_cnt, 1);
    enable = 1'b0;
    wait_idle();
    src_sel = 2'd3;
    enable  = 1'b1;
    tick(4);
    check("t5_oob_busy", busy, 0);
    check("t5_oob_s_tready", bus.s_axis_tready, 3'b111);
    enable = 1'b0;

    // 6: reset in the middle of a frame
    src_sel = 2'd0;
    enable  = 1'b1;
    tick(2);
    bus.m_axis_tready = 1'b0;
    for (int b = 0; b < 3; b++) send_beat(0, 'h7000 + b * 16, 'h7800 + b * 16, 1'b0);
    tick(2);
    check("t6_pre_valid", bus.m_axis_tvalid, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_tvalid", bus.m_axis_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    enable = 1'b0;
    bus.m_axis_tready = 1'b1;
    tick(1);
    reset = 1'b0;
    got_w.delete();
    got_l.delete();
    got_c.delete();
    exp_w.delete();
    tick(1);
    check("t6_idle_s_tready", bus.s_axis_tready, 3'b111);
    enable = 1'b1;
    tick(10);
    check("t6_fifo_empty_words", got_w.size(), 0);
    check("t6_fifo_empty_valid", bus.m_axis_tvalid, 0);
    enable = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
